// File: rtl/axilite_m.sv
// Purpose : AXI4-Lite master; turns local single-beat write/read commands into AXI4-Lite transactions.
// Latency : cmd accept -> rsp_valid in 3 edges (write and read) against a zero-wait responder.
// Backpr. : one transaction outstanding; cmd_ready only in IDLE; rsp_* held until rsp_ready.
//
// Ports:
//   m_axi_aclk / m_axi_aresetn       clock, asynchronous active-low reset
//   cmd_*                            local command (valid/ready, write, addr, wdata)
//   rsp_*                            local response (valid/ready, write, rdata, resp)
//   m_axi_aw* / w* / b* / ar* / r*   AXI4-Lite master channels
//   busy                             high whenever the FSM is not IDLE
//   wr_count / rd_count / err_count  wrapping completion counters

module axilite_m #(
    parameter int CNT_W = 16
) (
    input  logic             m_axi_aclk,
    input  logic             m_axi_aresetn,

    // local command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,

    // local response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_resp,

    // write address channel
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_awaddr,

    // write data channel
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    output logic [31:0]      m_axi_wdata,

    // write response channel
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,
    input  logic [1:0]       m_axi_bresp,

    // read address channel
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    output logic [31:0]      m_axi_araddr,

    // read data channel
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,

    // status
    output logic             busy,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state_q, state_d;

    // AXI request side
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q,  wvalid_d;
    logic             arvalid_q, arvalid_d;
    logic             bready_q,  bready_d;
    logic             rready_q,  rready_d;
    logic [31:0]      awaddr_q,  awaddr_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic [31:0]      araddr_q,  araddr_d;

    // AW and W complete independently; these remember which one already has
    logic             aw_done_q, aw_done_d;
    logic             w_done_q,  w_done_d;

    // local response holding registers
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_write_q, rsp_write_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       rsp_resp_q,  rsp_resp_d;

    // counters
    logic [CNT_W-1:0] wr_count_q,  wr_count_d;
    logic [CNT_W-1:0] rd_count_q,  rd_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // handshake decodes
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_fin, w_fin;

    assign aw_hs  = awvalid_q & m_axi_awready;
    assign w_hs   = wvalid_q  & m_axi_wready;
    assign b_hs   = m_axi_bvalid & bready_q;
    assign ar_hs  = arvalid_q & m_axi_arready;
    assign r_hs   = m_axi_rvalid & rready_q;

    // "done" includes a handshake completing on this very edge, so the last
    // of AW/W (or both together) moves straight on to WR_RESP
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q  | w_hs;

    // ------------------------------------------------------------------
    // next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        err_count_d = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // each valid drops only on its own handshake; address/data
                // registers are untouched here so they stay stable
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WR_RESP;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = 32'h0;
                    rsp_write_d = 1'b1;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    wr_count_d  = wr_count_q + CNT_W'(1);
                    if (m_axi_bresp != 2'b00) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    state_d     = RSP;
                end
            end

            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (r_hs) begin
                    rsp_resp_d  = m_axi_rresp;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_write_d = 1'b0;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rd_count_d  = rd_count_q + CNT_W'(1);
                    if (m_axi_rresp != 2'b00) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // state registers
    // ------------------------------------------------------------------
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= 32'h0;
            wdata_q     <= 32'h0;
            araddr_q    <= 32'h0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_resp_q  <= 2'b00;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    // gated with reset so the command port reads not-ready while held in reset
    assign cmd_ready     = (state_q == IDLE) & m_axi_aresetn;
    assign busy          = (state_q != IDLE);

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_rready  = rready_q;

    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;
    assign err_count     = err_count_q;

endmodule
